iterative_divider32: RTL and testbench
======================================

// Module: iterative_divider32
// PURPOSE
//  Multi-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
//  It is the inverse-arithmetic companion to the lookahead adder: one trial subtraction per cycle.
//  It sits beside the ALU in EX; the pipeline stalls while ready=0.
//  It is fed from ID/EX operands and returns a single 32-bit result.
// PARAMETERS
//  WIDTH   32   operand/result width; the iteration count equals WIDTH
// PORTS
//  clk           in   1      single clock; all state updates on rising edge
//  rst           in   1      asynchronous, active-high reset
//  start         in   1      request; accepted only when ready=1
//  flush         in   1      synchronous abort from the pipeline (branch/trap)
//  op            in   2      funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//  dividend      in   WIDTH  rs1 value, sampled on the accepting edge
//  divisor       in   WIDTH  rs2 value, sampled on the accepting edge
//  ready         out  1      1 in IDLE only
//  result_valid  out  1      one-cycle pulse, high in DONE
//  result        out  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU)
//  div_by_zero   out  1      qualified by result_valid; 1 if divisor was 0
// BEHAVIOUR
//  Reset (async): state=IDLE, ready=1, result_valid=0, result=0, div_by_zero=0, counters=0.
//  States:
//   IDLE  -> CALC on start, normal case.
//   IDLE  -> DONE on start, special case.
//   CALC  -> DONE after WIDTH iterations.
//   DONE  -> IDLE, unconditionally.
//  start is ignored in CALC and DONE: no queuing, no error.
//  Operand capture on the accepting edge:
//   - Signed ops (op[0]=0) take magnitudes |dividend| and |divisor|.
//   - neg_q = sign(dividend)^sign(divisor); neg_r = sign(dividend).
//   - Unsigned ops use raw values with neg_q=neg_r=0.
//  CALC, one restoring step per cycle, MSB first:
//   - rem = {rem[W-2:0], q_msb}; trial = rem - divisor computed in WIDTH+1 bits.
//   - trial >= 0: rem = trial, quotient bit = 1; otherwise rem is kept, bit = 0.
//   - Subtraction is rem + ~divisor + 1; the carry-out is the "no borrow" flag.
//  Result fix-up on the CALC->DONE edge:
//   - q = neg_q ? -q : q; r = neg_r ? -r : r (two's complement, WIDTH bits).
//   - result = op[1] ? r : q. result stays stable until the next accepted start.
//  Special cases, detected at accept time, take no iterations:
//   - Divisor==0: q = all ones, r = dividend (unmodified, any op); div_by_zero=1.
//   - Signed overflow, DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF:
//     q = 0x80000000, r = 0; div_by_zero=0.
//  Latency, with start accepted at edge 0:
//   - Normal: result_valid high in cycle 33 (WIDTH+1); ready returns in cycle 34.
//   - Special: result_valid high in cycle 1; ready returns in cycle 2.
//  Flush:
//   - In CALC or DONE: next state IDLE, result_valid forced 0 that cycle, result unchanged.
//   - Together with start in IDLE: flush wins and the request is dropped.
//  Reset asserted mid-operation: immediate return to reset values; no valid pulse afterwards.
//  No combinational path from inputs to outputs; every output is registered or decoded from state.
// TESTING
//  1 DIVU 100/7 -> result 14 at cycle 33; REMU same operands -> 2; ready low for cycles 1..33.
//  2 DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3); REM -> 0xFFFFFFFF(-1); REM 7/-2 -> 1.
//  3 DIVU 5/0 -> 0xFFFFFFFF with div_by_zero=1 at cycle 1; REM -9/0 -> 0xFFFFFFF7.
//  4 DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, valid at cycle 1, div_by_zero=0.
//  5 Start DIVU 0xFFFFFFFF/1, flush at cycle 10 -> no result_valid, ready=1 at cycle 11.
//    Start pulsed at cycle 5 of an active op -> ignored; only the first result is produced.
//  6 Assert rst at cycle 20 of an op -> ready=1, result=0 immediately.
//    Random signed/unsigned sweep (incl. 0, 1, -1, min int) vs golden model; back-to-back starts.

Source files
------------

// File: rtl/iterative_divider32.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// One trial subtraction per cycle; sign and special-case fix-up around the iteration core.
module iterative_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic             op_rem;

    // Operand conditioning at accept time.
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             is_zero_div;
    logic             is_ovf;

    assign a_neg       = ~op[0] & dividend[WIDTH-1];
    assign b_neg       = ~op[0] & divisor[WIDTH-1];
    assign mag_a       = a_neg ? -dividend : dividend;
    assign mag_b       = b_neg ? -divisor  : divisor;
    assign is_zero_div = (divisor == '0);
    assign is_ovf      = ~op[0] && (dividend == MIN_INT) && (divisor == '1);

    // One restoring step. The shifted partial remainder keeps its carried-out MSB
    // so divisors above 2^(WIDTH-1) still compare correctly.
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             last_step;

    always_comb begin
        // NOTE: every signal gets a value on every path so no latch is inferred.
        shifted   = {rem, quo[WIDTH-1]};
        diff      = {1'b0, shifted} + {1'b0, ~{1'b0, dvs}} + {{(WIDTH+1){1'b0}}, 1'b1};
        no_borrow = diff[WIDTH+1];
        rem_next  = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next  = {quo[WIDTH-2:0], no_borrow};
        q_fix     = neg_q ? -quo_next : quo_next;
        r_fix     = neg_r ? -rem_next : rem_next;
        last_step = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            rem          <= '0;
            quo          <= '0;
            dvs          <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            op_rem       <= 1'b0;
            ready        <= 1'b1;
            result_valid <= 1'b0;
            result       <= '0;
            div_by_zero  <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // A flush in the same cycle drops the request.
                    if (start && !flush) begin
                        ready <= 1'b0;
                        if (is_zero_div) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                            div_by_zero  <= 1'b1;
                            result       <= op[1] ? dividend : '1;
                        end else if (is_ovf) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                            div_by_zero  <= 1'b0;
                            result       <= op[1] ? '0 : MIN_INT;
                        end else begin
                            state  <= CALC;
                            count  <= '0;
                            rem    <= '0;
                            quo    <= mag_a;
                            dvs    <= mag_b;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            op_rem <= op[1];
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        rem   <= rem_next;
                        quo   <= quo_next;
                        count <= count + CW'(1);
                        if (last_step) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                            div_by_zero  <= 1'b0;
                            result       <= op_rem ? r_fix : q_fix;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_divider32.sv
// Self-checking bench for iterative_divider32: directed corner cases plus a randomized
// sweep, compared every cycle against an arithmetic reference model and timing queue.
module tb_iterative_divider32;

    localparam logic [31:0] MIN_INT = 32'h8000_0000;
    localparam logic [31:0] MAX_INT = 32'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        ready;
    logic        result_valid;
    logic [31:0] result;
    logic        div_by_zero;

    iterative_divider32 dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .flush        (flush),
        .op           (op),
        .dividend     (dividend),
        .divisor      (divisor),
        .ready        (ready),
        .result_valid (result_valid),
        .result       (result),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          busy_until = -1;
    logic [31:0] hold = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic with the RV32M special cases. Returns {dbz, result}.
    function automatic logic [32:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int          sa;
        int          sb;
        if (b == 0) return {1'b1, (o[1] ? a : 32'hFFFF_FFFF)};
        if (!o[0] && a == MIN_INT && b == 32'hFFFF_FFFF) return {1'b0, (o[1] ? 32'h0 : MIN_INT)};
        if (!o[0]) begin
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, (o[1] ? r : q)};
    endfunction

    // Compare process: after every edge, check ready, the valid pulse and the held result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            check("ready", 32'(ready), 32'(cyc > busy_until));
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                check("result_valid_pulse", 32'(result_valid), 32'd1);
                check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                hold = e.res;
            end else begin
                check("result_valid_idle", 32'(result_valid), 32'd0);
            end
            check("result", result, hold);
        end
    end

    // Called at a negedge with ready=1; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input bit use_lit, input logic [31:0] lit_res, input logic lit_dbz);
        logic [32:0] m;
        exp_t        e;
        bit          special;
        int          acc;
        m = model(o, a, b);
        if (use_lit) begin
            check("model_pin_res", m[31:0], lit_res);
            check("model_pin_dbz", 32'(m[32]), 32'(lit_dbz));
        end
        special = (b == 0) || (!o[0] && a == MIN_INT && b == 32'hFFFF_FFFF);
        acc     = cyc + 1;
        e.res   = m[31:0];
        e.dbz   = m[32];
        e.due   = special ? acc : acc + 32;
        exp_q.push_back(e);
        busy_until = e.due;
        op       = o;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit_res, input logic lit_dbz);
        start_op(o, a, b, 1'b1, lit_res, lit_dbz);
        wait_idle();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return MIN_INT;
            4:       return MAX_INT;
            5:       return 32'($urandom_range(0, 20));
            6:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        op       = 2'b00;
        dividend = '0;
        divisor  = '0;
        #1;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_valid", 32'(result_valid), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic unsigned and signed cases.
        run_op(2'b01, 32'd100, 32'd7, 32'd14, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 1'b0);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
        // Divide by zero and signed overflow take the single-cycle path.
        run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_op(2'b10, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 1'b1);
        run_op(2'b00, MIN_INT, 32'hFFFF_FFFF, MIN_INT, 1'b0);
        run_op(2'b10, MIN_INT, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 1'b0);

        // Flush at cycle 10 of an operation: no result, ready in cycle 11.
        start_op(2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        exp_q.delete(exp_q.size() - 1);
        busy_until = cyc;
        @(negedge clk);
        flush = 1'b0;
        wait_idle();

        // Start together with flush in IDLE is dropped.
        op       = 2'b01;
        dividend = 32'd9;
        divisor  = 32'd0;
        start    = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        repeat (2) @(negedge clk);

        // A start pulse in the middle of an operation is ignored.
        start_op(2'b01, 32'd1000, 32'd3, 1'b1, 32'd333, 1'b0);
        repeat (4) @(negedge clk);
        op       = 2'b00;
        dividend = 32'd77;
        divisor  = 32'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Asynchronous reset at cycle 20 of an operation.
        start_op(2'b01, 32'd50, 32'd5, 1'b1, 32'd10, 1'b0);
        repeat (19) @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        hold       = '0;
        busy_until = -1;
        #1;
        check("midop_reset_ready", 32'(ready), 32'd1);
        check("midop_reset_result", result, 32'd0);
        check("midop_reset_valid", 32'(result_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Randomized sweep with back-to-back starts and occasional gaps.
        for (int i = 0; i < 150; i++) begin
            start_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0, 32'd0, 1'b0);
            wait_idle();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
